// File: rtl/csi2_packet_tx_if.sv
// Request/pixel/byte-lane bundle between a CSI-2 packetizer (master) and its pixel source and PHY (slave).
interface csi2_packet_tx_if;
    logic       fs_i;
    logic       fe_i;
    logic       line_i;
    logic       px_valid_i;
    logic [9:0] px_data_i;
    logic       px_ready_o;
    logic       tx_req_o;
    logic       tx_rdy_i;
    logic [7:0] byte_o;
    logic       byte_en_o;
    logic       busy_o;
    logic [1:0] err_o;

    modport master (
        input  fs_i, fe_i, line_i, px_valid_i, px_data_i, tx_rdy_i,
        output px_ready_o, tx_req_o, byte_o, byte_en_o, busy_o, err_o
    );

    modport slave (
        output fs_i, fe_i, line_i, px_valid_i, px_data_i, tx_rdy_i,
        input  px_ready_o, tx_req_o, byte_o, byte_en_o, busy_o, err_o
    );
endinterface

// File: rtl/csi2_packet_tx.sv
// CSI-2 single-lane TX packetizer: FS/FE short packets and RAW10 long packets onto a D-PHY byte lane.
// Define CSI2_TX_CRC_EN for a real CRC-16 footer; otherwise the footer is two zero bytes.
module csi2_packet_tx #(
    parameter logic [1:0] VC      = 2'd0,
    parameter logic [5:0] DT      = 6'h2B,
    parameter int         HSIZE   = 1280,
    parameter int         GAP_CYC = 8
) (
    input  logic             display_clk,
    input  logic             reset_n_byte,
    csi2_packet_tx_if.master bus
);
    localparam logic [15:0] WC       = 16'(HSIZE * 5 / 4);
    localparam logic [15:0] PIX_MAX  = 16'(HSIZE);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    // Parity masks P5..P0 over {WC_H, WC_L, DI}, bit 0 = D0
    localparam logic [143:0] ECC_MASK = {24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
                                         24'h749A6D, 24'hF2555B, 24'hF12CB7};

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CRC, ST_GAP} state_t;

    state_t      state_reg;
    logic        tx_req_reg, byte_en_reg, busy_reg, is_long_reg, crc_idx_reg;
    logic        fs_pend_reg, fe_pend_reg, line_pend_reg;
    logic [7:0]  byte_reg, lsb_reg;
    logic [1:0]  err_reg, hdr_idx_reg;
    logic [31:0] hdr_reg;
    logic [15:0] frame_reg, byte_cnt_reg, pix_cnt_reg, gap_cnt_reg;
    logic [2:0]  slot_reg;

    logic        in_idle, in_payload, sel_fe, sel_fs, sel_line, sel_any;
    logic        consume, px_ready, take_px, req_drop;
    logic [15:0] frame_inc, hdr_wc_next;
    logic [7:0]  hdr_di_next, payload_byte, footer_byte;
    logic [23:0] ecc_data;
    logic [5:0]  ecc_bits;
    logic [9:0]  px_val;

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_payload = (state_reg == ST_PAYLOAD);
    assign sel_fe     = in_idle & fe_pend_reg;
    assign sel_fs     = in_idle & ~fe_pend_reg & fs_pend_reg;
    assign sel_line   = in_idle & ~fe_pend_reg & ~fs_pend_reg & line_pend_reg;
    assign sel_any    = sel_fe | sel_fs | sel_line;

    // Frame number skips 0 on wrap so a receiver never sees 0 after the first frame
    assign frame_inc   = (frame_reg == 16'hFFFF) ? 16'h0001 : frame_reg + 16'd1;
    assign hdr_di_next = sel_fe ? {VC, 6'h01} : (sel_fs ? {VC, 6'h00} : {VC, DT});
    assign hdr_wc_next = sel_line ? WC : (sel_fs ? frame_inc : frame_reg);
    assign ecc_data    = {hdr_wc_next, hdr_di_next};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ecc
            assign ecc_bits[gi] = ^(ecc_data & ECC_MASK[gi*24 +: 24]);
        end
    endgenerate

    assign consume      = tx_req_reg & bus.tx_rdy_i;
    assign px_ready     = in_payload & bus.tx_rdy_i & (slot_reg < 3'd4) & (pix_cnt_reg < PIX_MAX);
    assign take_px      = px_ready & tx_req_reg;
    assign px_val       = bus.px_valid_i ? bus.px_data_i : 10'd0;
    assign payload_byte = (slot_reg == 3'd4) ? lsb_reg : px_val[9:2];
    assign req_drop     = (bus.fs_i & fs_pend_reg & ~sel_fs) |
                          (bus.fe_i & fe_pend_reg & ~sel_fe) |
                          (bus.line_i & line_pend_reg & ~sel_line);

`ifdef CSI2_TX_CRC_EN
    logic [15:0] crc_reg;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge display_clk or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            crc_reg <= 16'hFFFF;
        end else if (sel_any) begin
            crc_reg <= 16'hFFFF;
        end else if (in_payload && consume) begin
            crc_reg <= crc_step(crc_reg, payload_byte);
        end
    end

    assign footer_byte = crc_idx_reg ? crc_reg[15:8] : crc_reg[7:0];
`else
    assign footer_byte = 8'h00;
`endif

    always_ff @(posedge display_clk or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            state_reg     <= ST_IDLE;
            tx_req_reg    <= 1'b0;
            byte_en_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            is_long_reg   <= 1'b0;
            crc_idx_reg   <= 1'b0;
            fs_pend_reg   <= 1'b0;
            fe_pend_reg   <= 1'b0;
            line_pend_reg <= 1'b0;
            byte_reg      <= 8'h00;
            lsb_reg       <= 8'h00;
            err_reg       <= 2'b00;
            hdr_idx_reg   <= 2'd0;
            hdr_reg       <= 32'h0;
            frame_reg     <= 16'h0;
            byte_cnt_reg  <= 16'h0;
            pix_cnt_reg   <= 16'h0;
            gap_cnt_reg   <= 16'h0;
            slot_reg      <= 3'd0;
        end else begin
            byte_en_reg   <= 1'b0;
            fs_pend_reg   <= (fs_pend_reg & ~sel_fs) | bus.fs_i;
            fe_pend_reg   <= (fe_pend_reg & ~sel_fe) | bus.fe_i;
            line_pend_reg <= (line_pend_reg & ~sel_line) | bus.line_i;
            if (req_drop) err_reg[0] <= 1'b1;
            if (take_px && !bus.px_valid_i) err_reg[1] <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (sel_any) begin
                        state_reg   <= ST_HDR;
                        tx_req_reg  <= 1'b1;
                        busy_reg    <= 1'b1;
                        is_long_reg <= sel_line;
                        hdr_idx_reg <= 2'd0;
                        hdr_reg     <= {2'b00, ecc_bits, hdr_wc_next, hdr_di_next};
                        if (sel_fs) frame_reg <= frame_inc;
                    end
                end
                ST_HDR: begin
                    if (consume) begin
                        byte_reg    <= hdr_reg[7:0];
                        byte_en_reg <= 1'b1;
                        hdr_reg     <= hdr_reg >> 8;
                        hdr_idx_reg <= hdr_idx_reg + 2'd1;
                        if (hdr_idx_reg == 2'd3) begin
                            if (is_long_reg) begin
                                state_reg    <= ST_PAYLOAD;
                                byte_cnt_reg <= 16'h0;
                                pix_cnt_reg  <= 16'h0;
                                slot_reg     <= 3'd0;
                            end else begin
                                state_reg   <= ST_GAP;
                                tx_req_reg  <= 1'b0;
                                gap_cnt_reg <= 16'h0;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (consume) begin
                        byte_reg    <= payload_byte;
                        byte_en_reg <= 1'b1;
                        slot_reg    <= (slot_reg == 3'd4) ? 3'd0 : slot_reg + 3'd1;
                        if (take_px) begin
                            lsb_reg[{slot_reg[1:0], 1'b0} +: 2] <= px_val[1:0];
                            pix_cnt_reg <= pix_cnt_reg + 16'd1;
                        end
                        if (byte_cnt_reg == WC - 16'd1) begin
                            state_reg    <= ST_CRC;
                            crc_idx_reg  <= 1'b0;
                            byte_cnt_reg <= 16'h0;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 16'd1;
                        end
                    end
                end
                ST_CRC: begin
                    if (consume) begin
                        byte_reg    <= footer_byte;
                        byte_en_reg <= 1'b1;
                        crc_idx_reg <= 1'b1;
                        if (crc_idx_reg) begin
                            state_reg   <= ST_GAP;
                            tx_req_reg  <= 1'b0;
                            gap_cnt_reg <= 16'h0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    tx_req_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.px_ready_o = px_ready;
    assign bus.tx_req_o   = tx_req_reg;
    assign bus.byte_o     = byte_reg;
    assign bus.byte_en_o  = byte_en_reg;
    assign bus.busy_o     = busy_reg;
    assign bus.err_o      = err_reg;
endmodule

// File: tb/tb_csi2_packet_tx.sv
// Directed bench for csi2_packet_tx with HSIZE=4: short/long packets, ordering, overflow, underrun, stall, reset.
module tb_csi2_packet_tx;
    logic display_clk = 1'b0;
    logic reset_n_byte = 1'b0;

    always #5 display_clk = ~display_clk;

    csi2_packet_tx_if bus ();

    csi2_packet_tx #(
        .VC(2'd0), .DT(6'h2B), .HSIZE(4), .GAP_CYC(8)
    ) dut (
        .display_clk (display_clk),
        .reset_n_byte(reset_n_byte),
        .bus         (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         lowc;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl_q[$];
    int         px_q[$];
    bit         fire;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC written straight from the definition (bit-serial, reflected poly)
    function automatic logic [15:0] exp_footer(input logic [7:0] pl[$]);
        logic [15:0] c;
        c = 16'h0000;
`ifdef CSI2_TX_CRC_EN
        c = 16'hFFFF;
        foreach (pl[k]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ pl[k][b]) c = (c >> 1) ^ 16'h8408;
                else                 c = c >> 1;
            end
        end
`endif
        return c;
    endfunction

    task automatic drive_px();
        if (px_q.size() > 0 && px_q[0] >= 0) begin
            bus.px_valid_i = 1'b1;
            bus.px_data_i  = 10'(px_q[0]);
        end else begin
            bus.px_valid_i = 1'b0;
            bus.px_data_i  = 10'd0;
        end
    endtask

    // One clock: note whether the current pixel slot is taken, capture the shown byte, end pulses
    task automatic tick();
        #1;
        fire = bus.px_ready_o && (px_q.size() > 0);
        @(posedge display_clk);
        #1;
        if (fire) void'(px_q.pop_front());
        if (bus.byte_en_o) rx_q.push_back(bus.byte_o);
        bus.fs_i = 1'b0;
        bus.fe_i = 1'b0;
        bus.line_i = 1'b0;
        drive_px();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq("byte_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (bus.busy_o && k < budget) begin
            tick();
            k++;
        end
        check_eq("idle", bus.busy_o, 1'b0);
    endtask

    task automatic check_pkt(input string tag);
        logic [7:0] got;
        foreach (exp_q[i]) begin
            got = 8'hxx;
            if (rx_q.size() > 0) got = rx_q.pop_front();
            check_eq($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
        end
        $display("[TB] packet %s: %0d bytes compared", tag, exp_q.size());
    endtask

    task automatic add_payload_and_footer();
        logic [15:0] f;
        f = exp_footer(pl_q);
        exp_q = {exp_q, pl_q};
        exp_q.push_back(f[7:0]);
        exp_q.push_back(f[15:8]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fs_i = 1'b0;
        bus.fe_i = 1'b0;
        bus.line_i = 1'b0;
        bus.px_valid_i = 1'b0;
        bus.px_data_i = 10'd0;
        bus.tx_rdy_i = 1'b1;
        repeat (3) @(posedge display_clk);
        #1;
        check_eq("rst_tx_req", bus.tx_req_o, 1'b0);
        check_eq("rst_byte_en", bus.byte_en_o, 1'b0);
        check_eq("rst_byte", bus.byte_o, 8'h00);
        check_eq("rst_busy", bus.busy_o, 1'b0);
        check_eq("rst_err", bus.err_o, 2'b00);
        check_eq("rst_px_ready", bus.px_ready_o, 1'b0);
        reset_n_byte = 1'b1;
        tick();

        // FS frame 1, then the inter-packet gap
        bus.fs_i = 1'b1;
        wait_bytes(4, 40);
        exp_q = {8'h00, 8'h01, 8'h00, 8'h1A};
        check_pkt("fs1");
        lowc = 0;
        if (!bus.tx_req_o) lowc++;
        repeat (7) begin
            tick();
            if (!bus.tx_req_o) lowc++;
        end
        check_eq("gap_low_cycles", lowc, 8);
        tick();
        check_eq("gap_end_busy", bus.busy_o, 1'b0);

        // RAW10 packing of one group
        px_q = {'h3FF, 'h000, 'h155, 'h2AA};
        drive_px();
        bus.line_i = 1'b1;
        wait_bytes(11, 80);
        exp_q = {8'h2B, 8'h05, 8'h00, 8'h2E};
        pl_q = {8'hFF, 8'h00, 8'h55, 8'hAA, 8'h93};
        add_payload_and_footer();
        check_pkt("line_a");
        wait_idle(40);
        check_eq("line_a_err", bus.err_o, 2'b00);
        check_eq("line_a_px_left", px_q.size(), 0);

        // FS and LINE together, FE arriving during the payload
        px_q = {1, 2, 3, 4};
        drive_px();
        bus.fs_i = 1'b1;
        bus.line_i = 1'b1;
        wait_bytes(9, 80);
        bus.fe_i = 1'b1;
        wait_bytes(19, 120);
        exp_q = {8'h00, 8'h02, 8'h00, 8'h1C};
        check_pkt("fs2");
        exp_q = {8'h2B, 8'h05, 8'h00, 8'h2E};
        pl_q = {8'h00, 8'h00, 8'h00, 8'h01, 8'h39};
        add_payload_and_footer();
        check_pkt("line_b");
        exp_q = {8'h01, 8'h02, 8'h00, 8'h1B};
        check_pkt("fe2");
        wait_idle(40);
        check_eq("order_err", bus.err_o, 2'b00);

        // Repeat LINE request while one is still pending
        px_q = {'h200, 'h100, 'h080, 'h040};
        drive_px();
        bus.fs_i = 1'b1;
        tick();
        bus.line_i = 1'b1;
        tick();
        bus.line_i = 1'b1;
        tick();
        check_eq("overflow_err", bus.err_o, 2'b01);
        wait_bytes(15, 120);
        exp_q = {8'h00, 8'h03, 8'h00, 8'h06};
        check_pkt("fs3");
        exp_q = {8'h2B, 8'h05, 8'h00, 8'h2E};
        pl_q = {8'h80, 8'h40, 8'h20, 8'h10, 8'h00};
        add_payload_and_footer();
        check_pkt("line_c");
        wait_idle(60);
        repeat (30) tick();
        check_eq("single_long_pkt", rx_q.size(), 0);

        // Reset in the middle of a payload
        px_q = {'h111, 'h222, 'h333, 'h044};
        drive_px();
        bus.line_i = 1'b1;
        wait_bytes(6, 80);
        reset_n_byte = 1'b0;
        #1;
        check_eq("rst_async_tx_req", bus.tx_req_o, 1'b0);
        check_eq("rst_async_busy", bus.busy_o, 1'b0);
        px_q.delete();
        drive_px();
        rx_q.delete();
        repeat (2) tick();
        reset_n_byte = 1'b1;
        tick();
        check_eq("post_rst_err", bus.err_o, 2'b00);
        check_eq("post_rst_nothing_sent", rx_q.size(), 0);
        bus.fs_i = 1'b1;
        wait_bytes(4, 40);
        exp_q = {8'h00, 8'h01, 8'h00, 8'h1A};
        check_pkt("fs_after_rst");
        wait_idle(40);

        // Underrun on pixel 2 plus a 3-cycle PHY stall
        px_q = {'h123, 'h234, -1, 'h0FF};
        drive_px();
        bus.line_i = 1'b1;
        wait_bytes(6, 40);
        bus.tx_rdy_i = 1'b0;
        lowc = 0;
        repeat (3) begin
            tick();
            if (!bus.byte_en_o) lowc++;
        end
        check_eq("stall_px_ready", bus.px_ready_o, 1'b0);
        check_eq("stall_byte_en_low", lowc, 3);
        bus.tx_rdy_i = 1'b1;
        wait_bytes(11, 60);
        exp_q = {8'h2B, 8'h05, 8'h00, 8'h2E};
        pl_q = {8'h48, 8'h8D, 8'h00, 8'h3F, 8'hC3};
        add_payload_and_footer();
        check_pkt("line_underrun");
        check_eq("underrun_err", bus.err_o, 2'b10);
        wait_idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
